// File: rtl/conv_seq_ctrl.sv
// Load/compute sequencer for a 1-D valid-window convolution engine.
// Streams X samples and filter taps into memory, then issues one MAC window per result.
module conv_seq_ctrl #(
    parameter int  X_SIZE = 128,
    parameter int  F_SIZE = 32,
    localparam int N_OUT  = X_SIZE - F_SIZE + 1,
    localparam int XW     = (X_SIZE > 1) ? $clog2(X_SIZE) : 1,
    localparam int FW     = (F_SIZE > 1) ? $clog2(F_SIZE) : 1,
    localparam int OW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    input  logic          s_valid_f,
    output logic          s_ready_f,
    output logic          xmem_wr_en,
    output logic [XW-1:0] xmem_addr,
    output logic          fmem_wr_en,
    output logic [FW-1:0] fmem_addr,
    output logic [OW-1:0] win_offset,
    output logic          y_load,
    output logic          m_valid_y,
    input  logic          m_ready_y,
    output logic          conv_done
);

    // state    | meaning
    // S_LOAD   | accepting X samples and filter taps until both are full
    // S_SETTLE | one idle cycle so the last memory writes land before reads
    // S_COMPUTE| issuing windows, one y_load per result slot freed downstream
    // S_DONE   | one-cycle conv_done pulse, counters cleared
    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_SETTLE  = 2'd1,
        S_COMPUTE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Counters carry one extra bit so they can hold the full count itself.
    localparam int CXW = $clog2(X_SIZE + 1);
    localparam int CFW = $clog2(F_SIZE + 1);
    localparam int COW = $clog2(N_OUT + 1);

    localparam logic [CXW-1:0] X_FULL = CXW'(X_SIZE);
    localparam logic [CFW-1:0] F_FULL = CFW'(F_SIZE);
    localparam logic [COW-1:0] N_FULL = COW'(N_OUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CXW-1:0]   r_x_cnt;
    logic [CFW-1:0]   r_f_cnt;
    logic [COW-1:0]   r_out_cnt;
    logic             r_m_valid;

    logic             w_x_fire;
    logic             w_f_fire;
    logic             w_accept;
    logic [CXW-1:0]   w_x_cnt_nxt;
    logic [CFW-1:0]   w_f_cnt_nxt;

    assign w_x_fire    = s_valid_x && s_ready_x;
    assign w_f_fire    = s_valid_f && s_ready_f;
    assign w_accept    = r_m_valid && m_ready_y;
    assign w_x_cnt_nxt = r_x_cnt + CXW'(w_x_fire);
    assign w_f_cnt_nxt = r_f_cnt + CFW'(w_f_fire);

    assign xmem_wr_en  = w_x_fire;
    assign fmem_wr_en  = w_f_fire;
    assign xmem_addr   = r_x_cnt[XW-1:0];
    assign fmem_addr   = r_f_cnt[FW-1:0];
    assign win_offset  = r_out_cnt[OW-1:0];
    assign m_valid_y   = r_m_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                // Leave on the edge of the final beat, even if X and F finish together.
                if ((w_x_cnt_nxt == X_FULL) && (w_f_cnt_nxt == F_FULL)) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_accept && (r_out_cnt == N_FULL)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_LOAD;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Strobes are masked during reset so nothing leaks out before the state register settles.
    always_comb begin
        s_ready_x = 1'b0;
        s_ready_f = 1'b0;
        y_load    = 1'b0;
        conv_done = 1'b0;
        if (!reset) begin
            case (r_state)
                S_LOAD: begin
                    s_ready_x = (r_x_cnt != X_FULL);
                    s_ready_f = (r_f_cnt != F_FULL);
                end
                S_COMPUTE: begin
                    y_load = (r_out_cnt < N_FULL) && (!r_m_valid || m_ready_y);
                end
                S_DONE: begin
                    conv_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_cnt   <= '0;
            r_f_cnt   <= '0;
            r_out_cnt <= '0;
            r_m_valid <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_x_cnt   <= '0;
            r_f_cnt   <= '0;
            r_out_cnt <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_x_cnt <= w_x_cnt_nxt;
            r_f_cnt <= w_f_cnt_nxt;
            if (y_load) begin
                r_out_cnt <= r_out_cnt + COW'(1);
                r_m_valid <= 1'b1;
            end else if (w_accept) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: load phases, streaming and stalled output,
// mid-job reset and back-to-back jobs, checked against a small cycle model.
module tb_conv_seq_ctrl;

    localparam int X  = 128;
    localparam int F  = 32;
    localparam int N  = X - F + 1;
    localparam int XW = $clog2(X);
    localparam int FW = $clog2(F);
    localparam int OW = $clog2(N);

    logic          clk;
    logic          reset;
    logic          s_valid_x;
    logic          s_ready_x;
    logic          s_valid_f;
    logic          s_ready_f;
    logic          xmem_wr_en;
    logic [XW-1:0] xmem_addr;
    logic          fmem_wr_en;
    logic [FW-1:0] fmem_addr;
    logic [OW-1:0] win_offset;
    logic          y_load;
    logic          m_valid_y;
    logic          m_ready_y;
    logic          conv_done;

    int checks   = 0;
    int failures = 0;

    conv_seq_ctrl #(.X_SIZE(X), .F_SIZE(F)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid_x  (s_valid_x),
        .s_ready_x  (s_ready_x),
        .s_valid_f  (s_valid_f),
        .s_ready_f  (s_ready_f),
        .xmem_wr_en (xmem_wr_en),
        .xmem_addr  (xmem_addr),
        .fmem_wr_en (fmem_wr_en),
        .fmem_addr  (fmem_addr),
        .win_offset (win_offset),
        .y_load     (y_load),
        .m_valid_y  (m_valid_y),
        .m_ready_y  (m_ready_y),
        .conv_done  (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: valids held high; mode 1: random gaps with X and F finishing on the same beat
    task automatic do_load(input int mode);
        int   xc  = 0;
        int   fc  = 0;
        int   cyc = 0;
        logic vx;
        logic vf;
        while ((xc < X || fc < F) && cyc < 3000) begin
            @(negedge clk);
            if (mode == 0) begin
                vx = 1'b1;
                vf = 1'b1;
            end else begin
                vx = ($urandom_range(0, 3) != 0);
                vf = ($urandom_range(0, 3) != 0);
                if (xc == X - 1 && fc < F - 1) vx = 1'b0;
                if (fc == F - 1) vf = (xc == X - 1) && vx;
            end
            s_valid_x = vx;
            s_valid_f = vf;
            m_ready_y = 1'($urandom_range(0, 1));
            #1;
            chk("load_rdy_x", s_ready_x, (xc < X));
            chk("load_rdy_f", s_ready_f, (fc < F));
            chk("load_xwr", xmem_wr_en, (vx && xc < X));
            chk("load_fwr", fmem_wr_en, (vf && fc < F));
            if (vx && xc < X) chk("load_xaddr", xmem_addr, xc);
            if (vf && fc < F) chk("load_faddr", fmem_addr, fc);
            chk("load_yload", y_load, 0);
            chk("load_mvalid", m_valid_y, 0);
            chk("load_done", conv_done, 0);
            if (vx && xc < X) xc++;
            if (vf && fc < F) fc++;
            cyc++;
        end
        if (cyc >= 3000) begin
            chk("load_timeout_x", xc, X);
            chk("load_timeout_f", fc, F);
        end
        // SETTLE: out-of-phase valids must not write
        @(negedge clk);
        s_valid_x = 1'b1;
        s_valid_f = 1'b1;
        #1;
        chk("settle_rdy_x", s_ready_x, 0);
        chk("settle_rdy_f", s_ready_f, 0);
        chk("settle_xwr", xmem_wr_en, 0);
        chk("settle_fwr", fmem_wr_en, 0);
        chk("settle_yload", y_load, 0);
        chk("settle_mvalid", m_valid_y, 0);
    endtask

    // mode 0: m_ready_y held high; mode 1: random ready plus a 10-cycle stall holding offset 50
    task automatic do_drain(input int mode, input int abort_at);
        int   issued     = 0;
        int   acc        = 0;
        int   held       = -1;
        int   stall      = 0;
        int   cyc        = 0;
        bit   stall_done = 0;
        bit   fin        = 0;
        bit   aborted    = 0;
        logic mv         = 1'b0;
        logic rdy;
        logic exp_yl;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            if (abort_at >= 0 && issued == abort_at) begin
                reset     = 1'b1;
                m_ready_y = 1'b1;
                s_valid_x = 1'b0;
                s_valid_f = 1'b0;
                aborted   = 1;
                break;
            end
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if (mv && held == 50 && !stall_done) begin
                rdy        = 1'b0;
                stall      = 9;
                stall_done = 1;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            m_ready_y = rdy;
            s_valid_x = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_valid_f = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            exp_yl = (issued < N) && (!mv || rdy);
            chk("cmp_yload", y_load, exp_yl);
            chk("cmp_mvalid", m_valid_y, mv);
            if (exp_yl) chk("cmp_offset", win_offset, issued);
            chk("cmp_xwr", xmem_wr_en, 0);
            chk("cmp_fwr", fmem_wr_en, 0);
            chk("cmp_rdy_x", s_ready_x, 0);
            chk("cmp_done", conv_done, 0);
            if (mv && rdy) acc++;
            if (exp_yl) begin
                held = issued;
                issued++;
                mv = 1'b1;
            end else if (mv && rdy) begin
                mv = 1'b0;
            end
            if (acc == N) fin = 1;
            cyc++;
        end
        if (aborted) begin
            @(negedge clk);
            #1;
            chk("abort_mvalid", m_valid_y, 0);
            chk("abort_done", conv_done, 0);
            chk("abort_rdy_x", s_ready_x, 0);
            chk("abort_yload", y_load, 0);
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("rst_rel_rdy_x", s_ready_x, 1);
            chk("rst_rel_rdy_f", s_ready_f, 1);
            chk("rst_rel_done", conv_done, 0);
        end else if (fin) begin
            @(negedge clk);
            s_valid_x = 1'b1;
            s_valid_f = 1'b1;
            m_ready_y = 1'b1;
            #1;
            chk("done_pulse", conv_done, 1);
            chk("done_mvalid", m_valid_y, 0);
            chk("done_rdy_x", s_ready_x, 0);
            chk("done_xwr", xmem_wr_en, 0);
            chk("done_yload", y_load, 0);
        end else begin
            chk("drain_timeout", acc, N);
        end
    endtask

    initial begin
        reset     = 1'b1;
        s_valid_x = 1'b1;
        s_valid_f = 1'b1;
        m_ready_y = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_rdy_x", s_ready_x, 0);
            chk("rst_rdy_f", s_ready_f, 0);
            chk("rst_xwr", xmem_wr_en, 0);
            chk("rst_fwr", fmem_wr_en, 0);
            chk("rst_mvalid", m_valid_y, 0);
            chk("rst_yload", y_load, 0);
            chk("rst_done", conv_done, 0);
        end
        @(negedge clk);
        reset     = 1'b0;
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        #1;
        chk("post_rst_rdy_x", s_ready_x, 1);
        chk("post_rst_rdy_f", s_ready_f, 1);

        do_load(0);
        do_drain(0, -1);

        do_load(1);
        do_drain(1, -1);

        do_load(0);
        do_drain(0, 40);

        do_load(0);
        do_drain(0, -1);

        @(negedge clk);
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        #1;
        chk("final_done_low", conv_done, 0);
        chk("final_xaddr", xmem_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
